// File: rtl/if_prefetch_queue_if.sv
// Fetch-side bus bundle for if_prefetch_queue.
//   redirect inputs : jump_taken/pc_jump, branch_taken/pc_branch, flush
//   imem port       : imem_addr (word address out), imem_rdata (comb data in)
//   decode port     : out_valid/out_ready handshake, out_instruction, out_pc_next
//   status          : q_count (occupied entries)
// slave  = the prefetch queue itself; master = the surrounding pipeline/memory.
interface if_prefetch_queue_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned IMEM_AW = 6,
  parameter int unsigned QDEPTH  = 4
);
  logic                       jump_taken;
  logic                       branch_taken;
  logic [XLEN-1:0]            pc_jump;
  logic [XLEN-1:0]            pc_branch;
  logic                       flush;
  logic [IMEM_AW-1:0]         imem_addr;
  logic [XLEN-1:0]            imem_rdata;
  logic                       out_valid;
  logic                       out_ready;
  logic [XLEN-1:0]            out_instruction;
  logic [XLEN-1:0]            out_pc_next;
  logic [$clog2(QDEPTH):0]    q_count;

  modport slave (
    input  jump_taken, branch_taken, pc_jump, pc_branch, flush,
    input  imem_rdata, out_ready,
    output imem_addr, out_valid, out_instruction, out_pc_next, q_count
  );

  modport master (
    output jump_taken, branch_taken, pc_jump, pc_branch, flush,
    output imem_rdata, out_ready,
    input  imem_addr, out_valid, out_instruction, out_pc_next, q_count
  );
endinterface

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue.
// Fetches one word per cycle from a combinational instruction memory at the
// word-aligned fetch PC and buffers {instruction, pc+4} in a QDEPTH-entry
// circular queue. The head entry is presented to decode with a valid/ready
// handshake. Jump/branch redirects reload the PC and empty the queue; flush
// empties the queue but keeps the PC.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : if_prefetch_queue_if.slave (redirects, imem port, decode port, q_count)
module if_prefetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     IMEM_AW  = 6,
  parameter int unsigned     QDEPTH   = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  if_prefetch_queue_if.slave    bus
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;

  // Fetch PC and queue bookkeeping
  logic [XLEN-1:0] r_pc;
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;

  // Queue storage (no reset needed: outputs are gated by r_count)
  logic [XLEN-1:0] r_q_instr [QDEPTH];
  logic [XLEN-1:0] r_q_pcn   [QDEPTH];

  logic            w_redirect;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_pc_plus4;
  logic            w_valid;
  logic            w_pop;
  logic            w_push;
  logic            w_not_full;

  // Redirect selection: jump wins over branch; low two bits forced to zero
  always_comb begin
    w_redirect = bus.jump_taken | bus.branch_taken;
    w_target   = bus.jump_taken ? bus.pc_jump : bus.pc_branch;
    w_target[1:0] = 2'b00;
  end

  always_comb begin
    w_pc_plus4 = r_pc + XLEN'(4);
    w_valid    = (r_count != '0);
    w_not_full = (r_count < CW'(QDEPTH));
    w_pop      = w_valid & bus.out_ready;
    // A full queue may still accept the fetched word when the head leaves
    // on the same edge, so push depends on pop; imem_addr does not.
    w_push     = ~w_redirect & ~bus.flush & (w_not_full | w_pop);
  end

  // PC and pointer state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= RESET_PC;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_redirect) begin
      r_pc    <= w_target;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (bus.flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_pc   <= w_pc_plus4;
        r_tail <= r_tail + PW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage write
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_instr[r_tail] <= bus.imem_rdata;
      r_q_pcn[r_tail]   <= w_pc_plus4;
    end
  end

  // Outputs
  always_comb begin
    bus.imem_addr       = r_pc[IMEM_AW+1:2];
    bus.q_count         = r_count;
    bus.out_valid       = w_valid;
    bus.out_instruction = w_valid ? r_q_instr[r_head] : '0;
    bus.out_pc_next     = w_valid ? r_q_pcn[r_head]   : '0;
  end

endmodule

// File: tb/tb_if_prefetch_queue.sv
module tb_if_prefetch_queue;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned IMEM_AW = 6;
  localparam int unsigned QDEPTH  = 4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  logic [XLEN-1:0] imem [64];

  if_prefetch_queue_if #(.XLEN(XLEN), .IMEM_AW(IMEM_AW), .QDEPTH(QDEPTH)) bus ();

  if_prefetch_queue #(
    .XLEN(XLEN), .IMEM_AW(IMEM_AW), .QDEPTH(QDEPTH), .RESET_PC(32'h0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  assign bus.imem_rdata = imem[bus.imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.jump_taken   = 1'b0;
    bus.branch_taken = 1'b0;
    bus.pc_jump      = '0;
    bus.pc_branch    = '0;
    bus.flush        = 1'b0;
    bus.out_ready    = 1'b0;
  endtask

  // Reset asserted mid-cycle and released on the falling edge
  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    clear_inputs();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0h exp 0", bus.out_valid); end
    n_cmp++; if (bus.q_count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", bus.q_count); end
    n_cmp++; if (bus.imem_addr !== 6'd0) begin n_err++; $display("FAIL reset_addr got %0d exp 0", bus.imem_addr); end
    n_cmp++; if (bus.out_instruction !== 32'h0) begin n_err++; $display("FAIL reset_instr got %0h exp 0", bus.out_instruction); end
    n_cmp++; if (bus.out_pc_next !== 32'h0) begin n_err++; $display("FAIL reset_pcn got %0h exp 0", bus.out_pc_next); end
  endtask

  task automatic test_streaming();
    logic [31:0] exp_i [3] = '{32'h1000, 32'h1001, 32'h1002};
    logic [31:0] exp_p [3] = '{32'd4, 32'd8, 32'd12};
    do_reset();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (bus.out_instruction !== exp_i[k]) begin n_err++; $display("FAIL stream_instr[%0d] got %0h exp %0h", k, bus.out_instruction, exp_i[k]); end
      n_cmp++; if (bus.out_pc_next !== exp_p[k]) begin n_err++; $display("FAIL stream_pcn[%0d] got %0h exp %0h", k, bus.out_pc_next, exp_p[k]); end
      n_cmp++; if (bus.q_count !== 3'd1) begin n_err++; $display("FAIL stream_count[%0d] got %0d exp 1", k, bus.q_count); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_i;
    do_reset();
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 4) begin
        n_cmp++; if (bus.q_count !== 3'd4) begin n_err++; $display("FAIL bp_fill_count got %0d exp 4", bus.q_count); end
      end
    end
    n_cmp++; if (bus.q_count !== 3'd4) begin n_err++; $display("FAIL bp_sat_count got %0d exp 4", bus.q_count); end
    n_cmp++; if (bus.imem_addr !== 6'd4) begin n_err++; $display("FAIL bp_hold_addr got %0d exp 4", bus.imem_addr); end
    n_cmp++; if (bus.out_instruction !== 32'h1000) begin n_err++; $display("FAIL bp_head got %0h exp 1000", bus.out_instruction); end
    n_cmp++; if (bus.out_pc_next !== 32'd4) begin n_err++; $display("FAIL bp_head_pcn got %0h exp 4", bus.out_pc_next); end
    // Full queue with pop: one in, one out per cycle, count stays at 4
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      exp_i = 32'h1000 + 32'(k);
      n_cmp++; if (bus.out_instruction !== exp_i) begin n_err++; $display("FAIL full_pp_instr[%0d] got %0h exp %0h", k, bus.out_instruction, exp_i); end
      n_cmp++; if (bus.out_pc_next !== 32'(4 * (k + 1))) begin n_err++; $display("FAIL full_pp_pcn[%0d] got %0h exp %0h", k, bus.out_pc_next, 4 * (k + 1)); end
      n_cmp++; if (bus.q_count !== 3'd4) begin n_err++; $display("FAIL full_pp_count[%0d] got %0d exp 4", k, bus.q_count); end
      n_cmp++; if (bus.imem_addr !== 6'(4 + k)) begin n_err++; $display("FAIL full_pp_addr[%0d] got %0d exp %0d", k, bus.imem_addr, 4 + k); end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    bus.out_ready = 1'b0;
    tick(); tick(); tick();
    n_cmp++; if (bus.q_count !== 3'd3) begin n_err++; $display("FAIL redir_pre_count got %0d exp 3", bus.q_count); end
    bus.jump_taken   = 1'b1; bus.pc_jump   = 32'h40;
    bus.branch_taken = 1'b1; bus.pc_branch = 32'h80;
    bus.out_ready    = 1'b1;
    tick();
    n_cmp++; if (bus.q_count !== 3'd0) begin n_err++; $display("FAIL redir_count got %0d exp 0", bus.q_count); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL redir_valid got %0h exp 0", bus.out_valid); end
    n_cmp++; if (bus.imem_addr !== 6'd16) begin n_err++; $display("FAIL redir_addr got %0d exp 16", bus.imem_addr); end
    bus.jump_taken = 1'b0; bus.branch_taken = 1'b0; bus.out_ready = 1'b0;
    tick();
    n_cmp++; if (bus.out_instruction !== 32'h1010) begin n_err++; $display("FAIL redir_instr got %0h exp 1010", bus.out_instruction); end
    n_cmp++; if (bus.out_pc_next !== 32'h44) begin n_err++; $display("FAIL redir_pcn got %0h exp 44", bus.out_pc_next); end
    n_cmp++; if (bus.q_count !== 3'd1) begin n_err++; $display("FAIL redir_post_count got %0d exp 1", bus.q_count); end
  endtask

  task automatic test_misaligned();
    bus.branch_taken = 1'b1; bus.pc_branch = 32'h23;
    tick();
    n_cmp++; if (bus.imem_addr !== 6'd8) begin n_err++; $display("FAIL misal_addr got %0d exp 8", bus.imem_addr); end
    n_cmp++; if (bus.q_count !== 3'd0) begin n_err++; $display("FAIL misal_count got %0d exp 0", bus.q_count); end
    bus.branch_taken = 1'b0;
    tick();
    n_cmp++; if (bus.out_instruction !== 32'h1008) begin n_err++; $display("FAIL misal_instr got %0h exp 1008", bus.out_instruction); end
    n_cmp++; if (bus.out_pc_next !== 32'h24) begin n_err++; $display("FAIL misal_pcn got %0h exp 24", bus.out_pc_next); end
  endtask

  task automatic test_flush();
    do_reset();
    bus.out_ready = 1'b0;
    tick(); tick();
    bus.flush = 1'b1;
    tick();
    n_cmp++; if (bus.q_count !== 3'd0) begin n_err++; $display("FAIL flush_count got %0d exp 0", bus.q_count); end
    n_cmp++; if (bus.imem_addr !== 6'd2) begin n_err++; $display("FAIL flush_addr got %0d exp 2", bus.imem_addr); end
    bus.flush = 1'b0;
    tick();
    n_cmp++; if (bus.out_instruction !== 32'h1002) begin n_err++; $display("FAIL flush_instr got %0h exp 1002", bus.out_instruction); end
    n_cmp++; if (bus.out_pc_next !== 32'd12) begin n_err++; $display("FAIL flush_pcn got %0h exp c", bus.out_pc_next); end
    // Flush together with a redirect acts as the redirect
    bus.flush = 1'b1; bus.jump_taken = 1'b1; bus.pc_jump = 32'h11;
    tick();
    n_cmp++; if (bus.imem_addr !== 6'd4) begin n_err++; $display("FAIL flush_redir_addr got %0d exp 4", bus.imem_addr); end
    n_cmp++; if (bus.q_count !== 3'd0) begin n_err++; $display("FAIL flush_redir_count got %0d exp 0", bus.q_count); end
    bus.flush = 1'b0; bus.jump_taken = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.out_ready = 1'b1;
    tick(); tick(); tick();
    n_cmp++; if (bus.out_instruction !== 32'h1002) begin n_err++; $display("FAIL ares_pre_instr got %0h exp 1002", bus.out_instruction); end
    bus.jump_taken = 1'b1; bus.pc_jump = 32'h40;
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL ares_valid got %0h exp 0", bus.out_valid); end
    n_cmp++; if (bus.out_instruction !== 32'h0) begin n_err++; $display("FAIL ares_instr got %0h exp 0", bus.out_instruction); end
    n_cmp++; if (bus.out_pc_next !== 32'h0) begin n_err++; $display("FAIL ares_pcn got %0h exp 0", bus.out_pc_next); end
    n_cmp++; if (bus.q_count !== 3'd0) begin n_err++; $display("FAIL ares_count got %0d exp 0", bus.q_count); end
    n_cmp++; if (bus.imem_addr !== 6'd0) begin n_err++; $display("FAIL ares_addr got %0d exp 0", bus.imem_addr); end
    bus.jump_taken = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    n_cmp++; if (bus.out_instruction !== 32'h1000) begin n_err++; $display("FAIL ares_first_instr got %0h exp 1000", bus.out_instruction); end
    n_cmp++; if (bus.out_pc_next !== 32'd4) begin n_err++; $display("FAIL ares_first_pcn got %0h exp 4", bus.out_pc_next); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 64; i++) imem[i] = 32'h1000 + 32'(i);
    rst_n = 1'b0;
    clear_inputs();
    #2;
    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect();
    test_misaligned();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/if_prefetch_queue.md
IF_PREFETCH_QUEUE -- requirements
Module: if_prefetch_queue

Interface
REQ-001 SHALL have parameter XLEN, 32, data and PC width in bits.
REQ-002 SHALL have parameter IMEM_AW, 6, instruction-memory word-address width.
REQ-003 SHALL have parameter QDEPTH, 4, prefetch queue entries; power of two, at least 2.
REQ-004 SHALL have parameter RESET_PC, 0, PC value loaded on reset.
REQ-005 SHALL have port clk input 1, rising-edge clock.
REQ-006 SHALL have port rst_n input 1, asynchronous active-low reset.
REQ-007 SHALL have port jump_taken input 1, redirect request to pc_jump.
REQ-008 SHALL have port branch_taken input 1, redirect request to pc_branch.
REQ-009 SHALL have port pc_jump input XLEN, jump target.
REQ-010 SHALL have port pc_branch input XLEN, branch target.
REQ-011 SHALL have port flush input 1, discard queue contents without changing the PC.
REQ-012 SHALL have port imem_addr output IMEM_AW, word address to the instruction memory, equal to pc[IMEM_AW+1:2].
REQ-013 SHALL have port imem_rdata input XLEN, combinational instruction-memory read data.
REQ-014 SHALL have port out_valid output 1, head entry is valid.
REQ-015 SHALL have port out_ready input 1, decode accepts the head entry.
REQ-016 SHALL have port out_instruction output XLEN, head instruction, 0 when out_valid=0.
REQ-017 SHALL have port out_pc_next output XLEN, head fetch PC + 4, 0 when out_valid=0.
REQ-018 SHALL have port q_count output $clog2(QDEPTH)+1, number of occupied entries.

Function
REQ-019 SHALL hold the fetch PC in a register that is always word-aligned; target bits [1:0] are written as 0.
REQ-020 SHALL define pop = out_valid and out_ready.
REQ-021 SHALL define push = no redirect, no flush, and (q_count < QDEPTH or pop).
REQ-022 SHALL, on push, write {imem_rdata, pc+4} at the tail and advance pc by 4 on the same edge.
REQ-023 SHALL, on pop, advance the head pointer; simultaneous push and pop keeps q_count unchanged, including when full.
REQ-024 SHALL hold pc and perform no push when the queue is full and there is no pop (backpressure stall).
REQ-025 SHALL give redirect priority jump_taken over branch_taken.
REQ-026 SHALL, on redirect, load pc with the selected target, empty the queue (q_count=0), and perform no push that edge; a pop the same cycle is discarded.
REQ-027 SHALL, on flush without redirect, empty the queue and hold pc.
REQ-028 SHALL, when redirect and flush coincide, behave as a redirect.
REQ-029 SHALL give one-cycle fetch-to-output latency: an entry pushed on edge N is visible on the outputs after edge N when the queue was empty.
REQ-030 SHALL drive out_* combinationally from the head entry, gated to 0 when empty.
REQ-031 SHALL wrap head and tail pointers modulo QDEPTH; pc wraps modulo 2^XLEN.
REQ-032 SHALL have no combinational path from out_ready to imem_addr.

Reset
REQ-033 SHALL, on rst_n low and asynchronously, set pc=RESET_PC, head=tail=0, q_count=0, out_valid=0, out_instruction=0, out_pc_next=0.
REQ-034 SHALL, after rst_n is released, begin fetching at RESET_PC on the first rising edge.
REQ-035 SHALL, on reset asserted mid-operation, discard all entries and any pending redirect.

Verification
REQ-036 Streaming: imem[i]=0x1000+i, out_ready=1 -> outputs show out_instruction 0x1000, 0x1001, 0x1002 with out_pc_next 4, 8, 12 on consecutive cycles.
REQ-037 Backpressure: out_ready=0 for 10 cycles -> q_count saturates at 4 and pc holds at 16; on release the outputs show 0x1000..0x1003 in order with none lost.
REQ-038 Redirect: jump_taken=1, pc_jump=0x40 with branch_taken=1, pc_branch=0x80, queue holding 3 entries -> next cycle q_count=0 and out_valid=0; the following cycle out_instruction=imem[16] and out_pc_next=0x44.
REQ-039 Misaligned target: pc_branch=0x23 -> imem_addr=8 and out_pc_next=0x24.
REQ-040 Full with simultaneous push and pop: queue full, out_ready=1 -> q_count stays 4 and one entry enters and one leaves per cycle.
REQ-041 Async reset mid-stream: rst_n pulsed low between clock edges -> outputs go to 0 immediately; after release the first output is imem[RESET_PC/4].
